// File: rtl/vgg16_ctrl_pkg.sv
// Shared state encoding and default sizing for the VGG16 conv-block sequencer.
// Pure declarations: no logic, no latency, no flow control.
package vgg16_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ISSUE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_FINISH = 3'd3,
        ST_ERR    = 3'd4
    } seq_state_t;

    localparam int          DEF_NUM_BLOCKS     = 5;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 32'd4000000;
    localparam int          DEF_CNT_WIDTH      = 32;

    // Block-index width; a single-block chain still needs a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vgg16_block_sequencer_if.sv
// Control bundle between a run controller (master) and the block sequencer (slave).
// Wires only: no latency; start/done pulses are single-cycle and carry no backpressure.
interface vgg16_block_sequencer_if import vgg16_ctrl_pkg::*; #(
    parameter int NUM_BLOCKS = DEF_NUM_BLOCKS,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) ();
    localparam int IDX_W = idx_width(NUM_BLOCKS);

    logic                  i_start;
    logic                  i_abort;
    logic [NUM_BLOCKS-1:0] i_blk_done;
    logic [NUM_BLOCKS-1:0] o_blk_start;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_error;
    logic [IDX_W-1:0]      o_cur_block;
    logic [CNT_WIDTH-1:0]  o_cycle_count;

    modport master (
        output i_start, i_abort, i_blk_done,
        input  o_blk_start, o_busy, o_done, o_error, o_cur_block, o_cycle_count
    );

    modport slave (
        input  i_start, i_abort, i_blk_done,
        output o_blk_start, o_busy, o_done, o_error, o_cur_block, o_cycle_count
    );
endinterface

// File: rtl/vgg16_sat_counter.sv
// Clearable, enabled up-counter that sticks at all-ones; one cycle clear/enable to q.
// No flow control; clear has priority over enable.
module vgg16_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end
endmodule

// File: rtl/vgg16_block_sequencer.sv
// Fires each conv block in turn and waits for its completion; start pulse 1 cycle after i_start/done.
// No backpressure: i_start is dropped while busy, i_abort overrides everything.
module vgg16_block_sequencer import vgg16_ctrl_pkg::*; #(
    parameter int          NUM_BLOCKS     = DEF_NUM_BLOCKS,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          CNT_WIDTH      = DEF_CNT_WIDTH
) (
    input logic                    clk,
    input logic                    rst,
    vgg16_block_sequencer_if.slave bus
);
    localparam int                   IDX_W    = idx_width(NUM_BLOCKS);
    localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    seq_state_t            state_q, state_d;
    logic [IDX_W-1:0]      cur_q, cur_d;
    logic [NUM_BLOCKS-1:0] blk_start_q;
    logic                  busy_q, done_q, error_q;
    logic                  cyc_clr, cyc_en, tmo_clr, tmo_en;
    logic [CNT_WIDTH-1:0]  cyc_q, tmo_q;
    logic [NUM_BLOCKS-1:0] cur_mask;
    logic                  cur_done, spurious, timeout_hit;

    assign cur_mask    = NUM_BLOCKS'(1) << cur_q;
    assign cur_done    = |(bus.i_blk_done & cur_mask);
    assign spurious    = |(bus.i_blk_done & ~cur_mask);
    // tmo_q counts completed WAIT cycles, so the current one is the last allowed at TIMEOUT-1.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);
    assign cyc_en      = (state_q == ST_ISSUE) || (state_q == ST_WAIT) || (state_q == ST_FINISH);

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        cyc_clr = 1'b0;
        tmo_clr = 1'b0;
        tmo_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_d = ST_ISSUE;
                    cur_d   = '0;
                    cyc_clr = 1'b1;
                end
            end
            ST_ISSUE: begin
                tmo_clr = 1'b1;
                state_d = (spurious || cur_done) ? ST_ERR : ST_WAIT;
            end
            ST_WAIT: begin
                tmo_en = 1'b1;
                if (spurious) begin
                    state_d = ST_ERR;
                end else if (cur_done) begin
                    if (cur_q == LAST_IDX) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_ISSUE;
                        cur_d   = cur_q + IDX_W'(1);
                    end
                end else if (timeout_hit) begin
                    state_d = ST_ERR;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
        if (bus.i_abort) begin
            state_d = ST_IDLE;
            cur_d   = cur_q;
            cyc_clr = 1'b0;
        end
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            blk_start_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            blk_start_q <= (state_d == ST_ISSUE) ? (NUM_BLOCKS'(1) << cur_d) : '0;
            busy_q      <= (state_d == ST_ISSUE) || (state_d == ST_WAIT);
            done_q      <= (state_d == ST_FINISH);
            error_q     <= (state_d == ST_ERR);
        end
    end

    vgg16_sat_counter #(.WIDTH(CNT_WIDTH)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cyc_clr),
        .en  (cyc_en),
        .q   (cyc_q)
    );

    vgg16_sat_counter #(.WIDTH(CNT_WIDTH)) u_timeout_cnt (
        .clk (clk),
        .rst (rst),
        .clr (tmo_clr),
        .en  (tmo_en),
        .q   (tmo_q)
    );

    assign bus.o_blk_start   = blk_start_q;
    assign bus.o_busy        = busy_q;
    assign bus.o_done        = done_q;
    assign bus.o_error       = error_q;
    assign bus.o_cur_block   = cur_q;
    assign bus.o_cycle_count = cyc_q;
endmodule

// File: tb/tb_vgg16_block_sequencer.sv
// Directed bench for the block sequencer: normal run, timeout, spurious/early done, abort, async reset.
module tb_vgg16_block_sequencer;
    import vgg16_ctrl_pkg::*;

    localparam int NB  = 5;
    localparam int CW  = 32;
    localparam int TMO = 20;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    vgg16_block_sequencer_if #(.NUM_BLOCKS(NB), .CNT_WIDTH(CW)) bus ();

    vgg16_block_sequencer #(
        .NUM_BLOCKS     (NB),
        .TIMEOUT_CYCLES (TMO),
        .CNT_WIDTH      (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic start_run();
        bus.i_start = 1'b1;
        tick();
        bus.i_start = 1'b0;
    endtask

    task automatic do_abort();
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
    endtask

    // Entered mid-ISSUE of blk; block answers 10 cycles after its start pulse.
    task automatic respond(input int blk);
        logic [NB-1:0] exp;
        exp = NB'(1) << blk;
        chk("blk_start", 64'(bus.o_blk_start), 64'(exp));
        chk("cur_block", 64'(bus.o_cur_block), 64'(blk));
        tick();
        chk("start_wait", 64'(bus.o_blk_start), 64'd0);
        repeat (9) tick();
        bus.i_blk_done = exp;
        tick();
        bus.i_blk_done = '0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [NB-1:0] seen;
        logic          done_seen;

        bus.i_start    = 1'b0;
        bus.i_abort    = 1'b0;
        bus.i_blk_done = '0;
        rst            = 1'b1;
        #1;
        chk("rst_blk_start", 64'(bus.o_blk_start), 64'd0);
        chk("rst_busy", 64'(bus.o_busy), 64'd0);
        chk("rst_done", 64'(bus.o_done), 64'd0);
        chk("rst_error", 64'(bus.o_error), 64'd0);
        chk("rst_cur", 64'(bus.o_cur_block), 64'd0);
        chk("rst_count", 64'(bus.o_cycle_count), 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Normal run; i_start held through block 2 must be ignored.
        start_run();
        chk("run_busy", 64'(bus.o_busy), 64'd1);
        chk("run_count0", 64'(bus.o_cycle_count), 64'd0);
        respond(0);
        respond(1);
        bus.i_start = 1'b1;
        respond(2);
        bus.i_start = 1'b0;
        respond(3);
        respond(4);
        chk("finish_done", 64'(bus.o_done), 64'd1);
        chk("finish_busy", 64'(bus.o_busy), 64'd0);
        chk("finish_start", 64'(bus.o_blk_start), 64'd0);
        chk("finish_count", 64'(bus.o_cycle_count), 64'd55);
        tick();
        chk("idle_done", 64'(bus.o_done), 64'd0);
        chk("run_count", 64'(bus.o_cycle_count), 64'd56);

        // Completions in IDLE are ignored and the count holds.
        bus.i_blk_done = '1;
        tick();
        bus.i_blk_done = '0;
        tick();
        chk("idle_done_busy", 64'(bus.o_busy), 64'd0);
        chk("idle_done_err", 64'(bus.o_error), 64'd0);
        chk("idle_done_start", 64'(bus.o_blk_start), 64'd0);
        chk("idle_hold_count", 64'(bus.o_cycle_count), 64'd56);

        // Abort beats a simultaneous start in IDLE.
        bus.i_abort = 1'b1;
        bus.i_start = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        bus.i_start = 1'b0;
        chk("abort_vs_start_busy", 64'(bus.o_busy), 64'd0);
        chk("abort_vs_start_pulse", 64'(bus.o_blk_start), 64'd0);

        // Spurious completion from block 3 while waiting on block 1.
        start_run();
        respond(0);
        tick();
        bus.i_blk_done = 5'b01000;
        tick();
        bus.i_blk_done = '0;
        chk("spur_error", 64'(bus.o_error), 64'd1);
        chk("spur_cur", 64'(bus.o_cur_block), 64'd1);
        chk("spur_busy", 64'(bus.o_busy), 64'd0);
        do_abort();
        chk("spur_abort_err", 64'(bus.o_error), 64'd0);

        // Spurious bit alongside the correct one still errors.
        start_run();
        tick();
        bus.i_blk_done = 5'b00011;
        tick();
        bus.i_blk_done = '0;
        chk("spur_with_cur_err", 64'(bus.o_error), 64'd1);
        chk("spur_with_cur_idx", 64'(bus.o_cur_block), 64'd0);
        do_abort();

        // Completion during ISSUE is illegal.
        start_run();
        bus.i_blk_done = 5'b00001;
        tick();
        bus.i_blk_done = '0;
        chk("zero_lat_err", 64'(bus.o_error), 64'd1);
        chk("zero_lat_start", 64'(bus.o_blk_start), 64'd0);
        do_abort();

        // Timeout on block 2: ERR after exactly TMO wait cycles, no pulse to block 3.
        start_run();
        respond(0);
        respond(1);
        seen = '0;
        for (int i = 0; i < TMO; i++) begin
            tick();
            seen |= bus.o_blk_start;
        end
        chk("tmo_not_yet", 64'(bus.o_error), 64'd0);
        chk("tmo_busy_before", 64'(bus.o_busy), 64'd1);
        tick();
        seen |= bus.o_blk_start;
        chk("tmo_error", 64'(bus.o_error), 64'd1);
        chk("tmo_cur", 64'(bus.o_cur_block), 64'd2);
        chk("tmo_no_pulse", 64'(seen), 64'd0);
        chk("tmo_count", 64'(bus.o_cycle_count), 64'd43);
        bus.i_start    = 1'b1;
        bus.i_blk_done = '1;
        tick();
        bus.i_start    = 1'b0;
        bus.i_blk_done = '0;
        tick();
        chk("err_hold", 64'(bus.o_error), 64'd1);
        chk("err_cur_frozen", 64'(bus.o_cur_block), 64'd2);
        chk("err_no_start", 64'(bus.o_blk_start), 64'd0);
        chk("err_count_hold", 64'(bus.o_cycle_count), 64'd43);
        do_abort();
        chk("err_abort_clear", 64'(bus.o_error), 64'd0);

        // Abort while waiting on block 3, then restart from block 0.
        start_run();
        respond(0);
        respond(1);
        respond(2);
        tick();
        chk("abort_pre_cur", 64'(bus.o_cur_block), 64'd3);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        chk("abort_busy", 64'(bus.o_busy), 64'd0);
        chk("abort_done", 64'(bus.o_done), 64'd0);
        chk("abort_start", 64'(bus.o_blk_start), 64'd0);
        done_seen = 1'b0;
        repeat (3) begin
            tick();
            done_seen |= bus.o_done;
        end
        chk("abort_no_done", 64'(done_seen), 64'd0);
        start_run();
        chk("restart_pulse", 64'(bus.o_blk_start), 64'd1);
        chk("restart_cur", 64'(bus.o_cur_block), 64'd0);
        chk("restart_count", 64'(bus.o_cycle_count), 64'd0);
        do_abort();

        // Asynchronous reset in the middle of an ISSUE cycle.
        start_run();
        chk("pre_rst_pulse", 64'(bus.o_blk_start), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pulse", 64'(bus.o_blk_start), 64'd0);
        chk("async_rst_busy", 64'(bus.o_busy), 64'd0);
        chk("async_rst_count", 64'(bus.o_cycle_count), 64'd0);
        tick();
        rst = 1'b0;
        seen = '0;
        repeat (3) begin
            tick();
            seen |= bus.o_blk_start;
        end
        chk("post_rst_idle", 64'(seen), 64'd0);
        chk("post_rst_busy", 64'(bus.o_busy), 64'd0);
        start_run();
        chk("post_rst_restart", 64'(bus.o_blk_start), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vgg16_block_sequencer.md
VGG16_BLOCK_SEQUENCER -- requirements
Module: vgg16_block_sequencer

Interface
REQ-001 Parameter NUM_BLOCKS, default 5: number of chained conv blocks sequenced (block 0 .. NUM_BLOCKS-1).
REQ-002 Parameter TIMEOUT_CYCLES, default 32'd4000000: max WAIT cycles per block; 0 disables the timeout.
REQ-003 Parameter CNT_WIDTH, default 32: width of cycle and timeout counters.
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port i_start  input  1  run request; sampled only in IDLE.
REQ-007 Port i_abort  input  1  abort/clear; wins over every other input.
REQ-008 Port i_blk_done  input  NUM_BLOCKS  per-block o_valid completion pulses.
REQ-009 Port o_blk_start  output  NUM_BLOCKS  per-block one-cycle i_valid start pulses.
REQ-010 Port o_busy  output  1  high in ISSUE and WAIT.
REQ-011 Port o_done  output  1  one-cycle pulse: all blocks completed.
REQ-012 Port o_error  output  1  held high in ERR.
REQ-013 Port o_cur_block  output  $clog2(NUM_BLOCKS)  index of active block.
REQ-014 Port o_cycle_count  output  CNT_WIDTH  run length in cycles, saturating.

Function
REQ-015 FSM states: IDLE, ISSUE, WAIT, FINISH, ERR; all outputs registered.
REQ-016 IDLE and i_start=1 -> ISSUE with o_cur_block=0, o_cycle_count=0.
REQ-017 In ISSUE, o_blk_start[o_cur_block]=1, all other bits 0, for exactly one cycle; next state WAIT.
REQ-018 Latency: i_start at edge t -> o_blk_start[0] high during cycle t+1.
REQ-019 WAIT and i_blk_done[cur]=1, cur<NUM_BLOCKS-1 -> ISSUE, cur+1; next start pulse appears 1 cycle after done.
REQ-020 WAIT and i_blk_done[cur]=1, cur=NUM_BLOCKS-1 -> FINISH; o_done=1 for one cycle, then IDLE.
REQ-021 Any i_blk_done bit other than cur asserted in ISSUE or WAIT -> ERR (spurious completion), even if the cur bit is also set.
REQ-022 i_blk_done[cur] asserted during ISSUE -> ERR (zero-latency completion is illegal).
REQ-023 i_blk_done in IDLE, FINISH or ERR is ignored.
REQ-024 Timeout counter clears in ISSUE and increments each WAIT cycle; reaching TIMEOUT_CYCLES without done -> ERR; done on that same cycle wins.
REQ-025 o_cycle_count increments every cycle in ISSUE/WAIT/FINISH, saturates at all-ones, holds its value in IDLE/ERR until the next run.
REQ-026 ERR holds o_error=1, o_cur_block frozen at the failing block; i_start ignored; exit only by i_abort or rst.
REQ-027 i_abort=1 in any state -> IDLE next cycle; no start or done pulse is issued on that cycle; o_error clears.
REQ-028 i_start while busy is ignored (no queueing).

Reset
REQ-029 rst asynchronously forces IDLE; o_blk_start=0, o_busy=0, o_done=0, o_error=0, o_cur_block=0, o_cycle_count=0, timeout count=0.
REQ-030 rst asserted mid-run drops any in-flight start pulse immediately; first run after release requires a fresh i_start.

Structure
REQ-031 State encoding and default NUM_BLOCKS/TIMEOUT_CYCLES constants live in shared package vgg16_ctrl_pkg.
REQ-032 Single sub-module vgg16_sat_counter (clear, enable, saturating), instanced for the cycle and timeout counters; the FSM stays in the top module.

Verification
REQ-033 Normal run: NUM_BLOCKS=5, block models respond 10 cycles after start -> o_blk_start pulses 0..4 in order, 11 cycles apart, o_done once, o_cycle_count=56.
REQ-034 Timeout: TIMEOUT_CYCLES=20, block 2 never responds -> o_error high after 20 WAIT cycles, o_cur_block=2, no pulse to block 3.
REQ-035 Spurious done: during WAIT on block 1, pulse i_blk_done[3] -> ERR next cycle, o_cur_block=1.
REQ-036 Abort: i_abort during WAIT on block 3 -> IDLE next cycle, o_busy=0, no o_done; new i_start restarts at block 0.
REQ-037 Async reset: rst asserted mid-cycle during ISSUE -> o_blk_start cleared before the next edge; i_start during busy and i_blk_done in IDLE cause no state change.
